// File: rtl/cv32e40p_tmr_scrub_ctrl_pkg.sv
// cv32e40p_tmr_scrub_ctrl_pkg: shared types and constants for the TMR scrub controller
package cv32e40p_tmr_scrub_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, HALT, RESYNC, CHECK, FATAL} tmr_scrub_state_e;

    localparam logic [1:0] TMR_NO_MAJORITY   = 2'd3;
    localparam int         TMR_NUM_INSTANCES = 3;

    function automatic logic [TMR_NUM_INSTANCES-1:0] tmr_onehot(input logic [1:0] idx);
        return idx == TMR_NO_MAJORITY ? '0 : TMR_NUM_INSTANCES'(1) << idx;
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_scrub_ctrl_fault_sel.sv
// cv32e40p_tmr_fault_sel: lowest-index mismatching voter picks the replica to reload
module cv32e40p_tmr_fault_sel
    import cv32e40p_tmr_scrub_ctrl_pkg::*;
#(
    parameter int NUM_VOTERS = 22
) (
    input  logic [NUM_VOTERS-1:0]   mismatch_i,
    input  logic [2*NUM_VOTERS-1:0] faulty_replica_i,
    output logic                    any_o,
    output logic [1:0]              target_o
);

    always_comb begin
        target_o = TMR_NO_MAJORITY;
        for (int i = NUM_VOTERS - 1; i >= 0; i--)
            if (mismatch_i[i]) target_o = faulty_replica_i[2*i +: 2];
    end

    assign any_o = |mismatch_i;

endmodule

// File: rtl/cv32e40p_tmr_scrub_ctrl.sv
// cv32e40p_tmr_scrub_ctrl: halts the core, reloads the minority CSR replica and re-checks
module cv32e40p_tmr_scrub_ctrl
    import cv32e40p_tmr_scrub_ctrl_pkg::*;
#(
    parameter int NUM_VOTERS    = 22,
    parameter int ERR_CNT_W     = 16,
    parameter int MAX_RETRY     = 3,
    parameter int RESYNC_CYCLES = 4,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic                         clr_i,
    input  logic [NUM_VOTERS-1:0]        mismatch_i,
    input  logic [2*NUM_VOTERS-1:0]      faulty_replica_i,
    output logic                         halt_req_o,
    input  logic                         halt_ack_i,
    output logic [TMR_NUM_INSTANCES-1:0] resync_en_o,
    output logic                         busy_o,
    output logic                         fatal_o,
    output logic [ERR_CNT_W-1:0]         err_cnt_o,
    output logic [1:0]                   last_replica_o
);

    localparam int TO_W = $clog2(DRAIN_TIMEOUT);
    localparam int RS_W = RESYNC_CYCLES > 1 ? $clog2(RESYNC_CYCLES) : 1;
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [RS_W-1:0] RS_LOAD = RS_W'(RESYNC_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);

    tmr_scrub_state_e              state_q, state_d;
    logic [1:0]                    target_q, target_d, last_q, last_d, sel_target;
    logic [TO_W-1:0]               timeout_q, timeout_d;
    logic [RS_W-1:0]               resync_q, resync_d;
    logic [RT_W-1:0]               retry_q, retry_d;
    logic [ERR_CNT_W-1:0]          err_cnt_q, err_cnt_d;
    logic                          halt_q, halt_d, fatal_q, fatal_d, any_mm, err_inc;
    logic [TMR_NUM_INSTANCES-1:0]  resync_en_q, resync_en_d;

    cv32e40p_tmr_fault_sel #(.NUM_VOTERS(NUM_VOTERS)) u_fault_sel (
        .mismatch_i       (mismatch_i),
        .faulty_replica_i (faulty_replica_i),
        .any_o            (any_mm),
        .target_o         (sel_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            last_q      <= '0;
            timeout_q   <= '0;
            resync_q    <= '0;
            retry_q     <= '0;
            err_cnt_q   <= '0;
            halt_q      <= 1'b0;
            fatal_q     <= 1'b0;
            resync_en_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            last_q      <= last_d;
            timeout_q   <= timeout_d;
            resync_q    <= resync_d;
            retry_q     <= retry_d;
            err_cnt_q   <= err_cnt_d;
            halt_q      <= halt_d;
            fatal_q     <= fatal_d;
            resync_en_q <= resync_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        last_d    = last_q;
        timeout_d = timeout_q;
        resync_d  = resync_q;
        retry_d   = retry_q;
        err_inc   = 1'b0;
        case (state_q)
            IDLE: if (enable_i && any_mm) begin
                target_d  = sel_target;
                timeout_d = '0;
                retry_d   = '0;
                state_d   = sel_target == TMR_NO_MAJORITY ? FATAL : HALT;
            end
            HALT: begin
                timeout_d = timeout_q + 1'b1;
                if (halt_ack_i) begin
                    state_d  = RESYNC;
                    resync_d = RS_LOAD;
                end else if (timeout_q == TO_LAST) begin
                    state_d = FATAL;
                end
            end
            RESYNC: begin
                resync_d = resync_q - 1'b1;
                if (resync_q == '0) state_d = CHECK;
            end
            CHECK: if (!any_mm) begin
                state_d = IDLE;
                err_inc = 1'b1;
                last_d  = target_q;
            end else begin
                retry_d = retry_q + 1'b1;
                if (retry_q == RT_LAST) begin
                    state_d = FATAL;
                end else begin
                    target_d = sel_target;
                    resync_d = RS_LOAD;
                    state_d  = sel_target == TMR_NO_MAJORITY ? FATAL : RESYNC;
                end
            end
            FATAL: if (clr_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        halt_d      = state_d inside {HALT, RESYNC, CHECK};
        fatal_d     = state_d == FATAL;
        resync_en_d = state_d == RESYNC ? tmr_onehot(target_d) : '0;
        err_cnt_d   = clr_i ? '0 : err_cnt_q + ERR_CNT_W'(err_inc && !(&err_cnt_q));
    end

    assign halt_req_o     = halt_q;
    assign busy_o         = halt_q;
    assign fatal_o        = fatal_q;
    assign resync_en_o    = resync_en_q;
    assign err_cnt_o      = err_cnt_q;
    assign last_replica_o = last_q;

endmodule
